// File: rtl/cache_fill_ctrl_if.sv
// cache_fill_ctrl_if
// Groups every signal between the fill controller and the CPU, the cache
// compare/write port and the memory burst port.
//   master : the controller. It accepts CPU reads (REQ/A_CPU -> ACK/RDATA),
//            drives the cache port (C_WA, C_A, C_WORC, C_CEN, C_D; reads
//            C_Q, C_HIT) and the memory port (M_REQ, M_ADDR; reads
//            M_VALID, M_DATA).
//   slave  : the surrounding system (CPU, cache array, memory).
// Optional macro CACHE_FILL_STATS_EN adds HIT_CNT / MISS_CNT.
interface cache_fill_ctrl_if;
    logic         REQ;
    logic [15:0]  A_CPU;
    logic         ACK;
    logic [31:0]  RDATA;
    logic [5:0]   C_WA;
    logic [15:0]  C_A;
    logic         C_WORC;
    logic         C_CEN;
    logic [127:0] C_D;
    logic [127:0] C_Q;
    logic         C_HIT;
    logic         M_REQ;
    logic [15:0]  M_ADDR;
    logic         M_VALID;
    logic [31:0]  M_DATA;
`ifdef CACHE_FILL_STATS_EN
    logic [15:0]  HIT_CNT;
    logic [15:0]  MISS_CNT;

    modport master (
        input  REQ, A_CPU, C_Q, C_HIT, M_VALID, M_DATA,
        output ACK, RDATA, C_WA, C_A, C_WORC, C_CEN, C_D, M_REQ, M_ADDR,
        output HIT_CNT, MISS_CNT
    );
    modport slave (
        output REQ, A_CPU, C_Q, C_HIT, M_VALID, M_DATA,
        input  ACK, RDATA, C_WA, C_A, C_WORC, C_CEN, C_D, M_REQ, M_ADDR,
        input  HIT_CNT, MISS_CNT
    );
`else
    modport master (
        input  REQ, A_CPU, C_Q, C_HIT, M_VALID, M_DATA,
        output ACK, RDATA, C_WA, C_A, C_WORC, C_CEN, C_D, M_REQ, M_ADDR
    );
    modport slave (
        output REQ, A_CPU, C_Q, C_HIT, M_VALID, M_DATA,
        input  ACK, RDATA, C_WA, C_A, C_WORC, C_CEN, C_D, M_REQ, M_ADDR
    );
`endif
endinterface

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl
// CPU-side read controller for a 64-line x 128-bit direct-mapped cache.
// A read is looked up through the cache compare port; a hit returns the
// addressed word, a miss fetches the line as a 4-beat memory burst, writes
// it into the cache and then returns the word.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-high reset
//   bus  - cache_fill_ctrl_if.master (CPU, cache and memory signals)
// Optional macro CACHE_FILL_STATS_EN adds saturating HIT_CNT / MISS_CNT.
// All outputs are registered; each state's actions take effect on the
// clock edge at which that state is current.
module cache_fill_ctrl (
    input  logic              CLK,
    input  logic              RST,
    cache_fill_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, FILL, WRITE, RESP} state_t;

    state_t       state;
    logic [15:0]  addr_q;
    logic [1:0]   cnt;
    logic [127:0] line_q;
    logic         ack_q;
    logic [31:0]  rdata_q;
    logic [5:0]   c_wa_q;
    logic [15:0]  c_a_q;
    logic         c_worc_q;
    logic         c_cen_q;
    logic [127:0] c_d_q;
    logic         m_req_q;
    logic [15:0]  m_addr_q;
`ifdef CACHE_FILL_STATS_EN
    logic [15:0]  hit_cnt_q;
    logic [15:0]  miss_cnt_q;
`endif

    function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] sel);
        return line[{sel, 5'b0} +: 32];
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            addr_q   <= 16'd0;
            cnt      <= 2'd0;
            ack_q    <= 1'b0;
            rdata_q  <= 32'd0;
            c_wa_q   <= 6'd0;
            c_a_q    <= 16'd0;
            c_worc_q <= 1'b1;
            c_cen_q  <= 1'b1;
            c_d_q    <= 128'd0;
            m_req_q  <= 1'b0;
            m_addr_q <= 16'd0;
`ifdef CACHE_FILL_STATS_EN
            hit_cnt_q  <= 16'd0;
            miss_cnt_q <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ack_q   <= 1'b0;
                    c_cen_q <= 1'b1;
                    // ack_q is still high in the cycle after RESP, which
                    // blocks re-accepting a REQ the CPU has not yet dropped.
                    if (bus.REQ && !ack_q) begin
                        addr_q <= bus.A_CPU;
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    c_cen_q  <= 1'b0;
                    c_worc_q <= 1'b1;
                    c_wa_q   <= addr_q[7:2];
                    c_a_q    <= addr_q;
                    state    <= CHECK;
                end
                CHECK: begin
                    c_cen_q <= 1'b1;
                    if (bus.C_HIT) begin
                        rdata_q <= word_sel(bus.C_Q, addr_q[1:0]);
                        state   <= RESP;
`ifdef CACHE_FILL_STATS_EN
                        hit_cnt_q <= sat_inc(hit_cnt_q);
`endif
                    end else begin
                        cnt      <= 2'd0;
                        m_addr_q <= {addr_q[15:2], 2'b00};
                        state    <= FILL;
`ifdef CACHE_FILL_STATS_EN
                        miss_cnt_q <= sat_inc(miss_cnt_q);
`endif
                    end
                end
                FILL: begin
                    // Request stays up only until the first beat is taken;
                    // cnt is nonzero from then on until the line completes.
                    m_req_q <= (cnt == 2'd0) && !bus.M_VALID;
                    if (bus.M_VALID) begin
                        line_q[{cnt, 5'b0} +: 32] <= bus.M_DATA;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    c_cen_q  <= 1'b0;
                    c_worc_q <= 1'b0;
                    c_wa_q   <= addr_q[7:2];
                    c_a_q    <= addr_q;
                    c_d_q    <= line_q;
                    rdata_q  <= word_sel(line_q, addr_q[1:0]);
                    m_req_q  <= 1'b0;
                    state    <= RESP;
                end
                RESP: begin
                    c_cen_q  <= 1'b1;
                    c_worc_q <= 1'b1;
                    ack_q    <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ACK    = ack_q;
    assign bus.RDATA  = rdata_q;
    assign bus.C_WA   = c_wa_q;
    assign bus.C_A    = c_a_q;
    assign bus.C_WORC = c_worc_q;
    assign bus.C_CEN  = c_cen_q;
    assign bus.C_D    = c_d_q;
    assign bus.M_REQ  = m_req_q;
    assign bus.M_ADDR = m_addr_q;
`ifdef CACHE_FILL_STATS_EN
    assign bus.HIT_CNT  = hit_cnt_q;
    assign bus.MISS_CNT = miss_cnt_q;
`endif
endmodule

// File: tb/tb_cache_fill_ctrl.sv
`timescale 1ns/1ps
module tb_cache_fill_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_fill_ctrl_if bus();
    cache_fill_ctrl dut (.CLK(clk), .RST(rst), .bus(bus.master));

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [5:0]   wa;
        logic [15:0]  a;
        logic [127:0] d;
    } wr_t;

    logic [31:0] exp_ack_q[$];
    wr_t         exp_wr_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_ctrl"}, {bus.ACK, bus.C_CEN, bus.C_WORC, bus.M_REQ}, 4'b0110);
        check({name, "_regs"}, {bus.RDATA, bus.C_WA, bus.C_A, bus.M_ADDR}, 128'd0);
        check({name, "_cd"}, bus.C_D, 128'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents ACK or a write.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ACK === 1'b1) begin
                if (exp_ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ACK rdata=%h expected no ACK", bus.RDATA);
                end else begin
                    check("ack_rdata", bus.RDATA, exp_ack_q.pop_front());
                end
            end
            if (bus.C_CEN === 1'b0 && bus.C_WORC === 1'b0) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got write wa=%h d=%h expected none", bus.C_WA, bus.C_D);
                end else begin
                    wr_t e;
                    e = exp_wr_q.pop_front();
                    check("write_wa_a", {bus.C_WA, bus.C_A}, {e.wa, e.a});
                    check("write_d", bus.C_D, e.d);
                end
            end
        end
    end

    // One CPU read. data is C_Q on a hit or the burst line on a miss;
    // gaps holds idle cycles before each beat ({g3,g2,g1,g0}).
    task automatic do_read(input string name, input logic [15:0] addr, input logic hit,
                           input logic [127:0] data, input logic [7:0] gaps,
                           input logic spurious, input int abort_after, input logic hold,
                           input logic [31:0] exp_rdata, input int exp_lat);
        int beat = 0;
        int gl = 0;
        int lat = -1;
        int mreq_cycles = 0;
        logic started = 1'b0;
        logic got = 1'b0;
        logic aborted = 1'b0;
        gl = int'(gaps[1:0]);
        @(negedge clk);
        bus.REQ   = 1'b1;
        bus.A_CPU = addr;
        bus.C_HIT = hit;
        bus.C_Q   = hit ? data : 128'h0F0F0F0F_F0F0F0F0_12121212_34343434;
        if (abort_after < 0) begin
            exp_ack_q.push_back(exp_rdata);
            if (!hit) exp_wr_q.push_back({addr[7:2], addr, data});
        end
        @(posedge clk);
        #1 bus.A_CPU = ~addr;
        for (int c = 0; c < 200 && !got && !aborted; c++) begin
            @(negedge clk);
            bus.M_VALID = 1'b0;
            if (bus.ACK === 1'b1) begin
                got = 1'b1;
                lat = c;
            end else if (abort_after >= 0 && beat == abort_after) begin
                bus.REQ = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset_vals({name, "_after_rst"});
                aborted = 1'b1;
            end else begin
                if (bus.M_REQ === 1'b1) begin
                    mreq_cycles++;
                    if (!started) begin
                        started = 1'b1;
                        check({name, "_m_addr"}, bus.M_ADDR, {addr[15:2], 2'b00});
                    end
                end
                if (spurious && c == 0) begin
                    bus.M_VALID = 1'b1;
                    bus.M_DATA  = 32'hDEADBEEF;
                end else if (started && beat < 4) begin
                    if (gl > 0) begin
                        gl--;
                    end else begin
                        bus.M_VALID = 1'b1;
                        bus.M_DATA  = data[32*beat +: 32];
                        beat++;
                        if (beat < 4) gl = int'(gaps[2*beat +: 2]);
                    end
                end
            end
        end
        if (!aborted) begin
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout: got no ACK within 200 cycles expected ACK", name);
            end else begin
                check({name, "_latency"}, lat, exp_lat);
            end
            if (hit) check({name, "_mreq_cycles"}, mreq_cycles, 0);
            else     check({name, "_mreq_cycles"}, mreq_cycles, int'(gaps[1:0]) + 1);
            if (!hold) bus.REQ = 1'b0;
        end
    endtask

    initial begin
        int n;
        bus.REQ = 1'b0; bus.A_CPU = 16'd0; bus.C_HIT = 1'b0; bus.C_Q = 128'd0;
        bus.M_VALID = 1'b0; bus.M_DATA = 32'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // Cold miss, back-to-back beats: word 2 returned.
        do_read("cold_miss", 16'hAAAA, 1'b0, 128'h44444444_33333333_22222222_11111111,
                8'h00, 1'b0, -1, 1'b0, 32'h33333333, 9);
        // Hit, all words 0xA.
        do_read("hit", 16'hAAAA, 1'b1, {32{4'hA}}, 8'h00, 1'b0, -1, 1'b0, 32'hAAAAAAAA, 3);
        // Hit with word select 1.
        do_read("hit_word1", 16'h5555, 1'b1, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
                8'h00, 1'b0, -1, 1'b0, 32'hBBBBBBBB, 3);
        // Stalled burst, gaps 0,1,2,3 and a spurious beat during LOOKUP.
        do_read("stalled", 16'h1237, 1'b0, 128'hCAFEF00D_0BADBEEF_5A5A5A5A_A5A5A5A5,
                8'b11_10_01_00, 1'b1, -1, 1'b0, 32'hCAFEF00D, 15);
        // Reset after two beats, then stray beats while idle.
        do_read("abort", 16'h0F04, 1'b0, 128'h99999999_88888888_77777777_66666666,
                8'h00, 1'b0, 2, 1'b0, 32'd0, 0);
        bus.M_VALID = 1'b1;
        bus.M_DATA  = 32'hBAD0BAD0;
        repeat (2) @(negedge clk);
        bus.M_VALID = 1'b0;
        // Fresh fill after the aborted one; two idle cycles before beat 0.
        do_read("refill", 16'h0F04, 1'b0, 128'h89ABCDEF_76543210_FEDCBA98_01234567,
                8'b00_00_00_10, 1'b0, -1, 1'b0, 32'h01234567, 11);
        // Held REQ through ACK: the re-accept waits for ACK to clear.
        do_read("held1", 16'hAAAA, 1'b1, {32{4'hA}}, 8'h00, 1'b0, -1, 1'b1, 32'hAAAAAAAA, 3);
        bus.A_CPU = 16'hAAAA;
        exp_ack_q.push_back(32'hAAAAAAAA);
        n = -1;
        for (int c = 1; c <= 10 && n < 0; c++) begin
            @(negedge clk);
            if (bus.C_CEN === 1'b0) n = c;
        end
        check("held_lookup_delay", n, 3);
        n = -1;
        for (int c = 1; c <= 10 && n < 0; c++) begin
            @(negedge clk);
            if (bus.ACK === 1'b1) n = c;
        end
        check("held_ack_delay", n, 2);
        bus.REQ = 1'b0;

        repeat (5) @(negedge clk);
        check("pending_acks", exp_ack_q.size(), 0);
        check("pending_writes", exp_wr_q.size(), 0);
`ifdef CACHE_FILL_STATS_EN
        check("hit_cnt", bus.HIT_CNT, 16'd2);
        check("miss_cnt", bus.MISS_CNT, 16'd1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
